// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: sram-like master with one request in flight and a decode-stage register.
// Define FETCH_ADEL_EN to turn misaligned fetch PCs into an address-error instruction instead of a bus request.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_nextF,
  input  logic        stallD,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD,
  output logic [31:0] pcF,
  output logic        stall_req_if
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD,
    DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_dec_q, instr_dec_d;
  logic [31:0] pc_dec_q, pc_dec_d;
  logic        valid_dec_q, valid_dec_d;
  logic [31:0] hold_q, hold_d;

  logic        misaligned;
  logic        idle_halt;
  logic        deliver;
  logic        deliver_adel;
  logic [31:0] deliver_data;

`ifdef FETCH_ADEL_EN
  logic adel_dec_q, adel_dec_d;
  logic halt_q, halt_d;

  assign misaligned = (pc_f_q[1:0] != 2'b00);
  assign idle_halt  = halt_q;
  assign adelD      = adel_dec_q;

  // The address-error marker follows the decode register; the halt flag parks the stage in IDLE until a redirect.
  always_comb begin
    adel_dec_d = adel_dec_q;
    halt_d     = halt_q;
    if (flush) begin
      adel_dec_d = 1'b0;
      halt_d     = 1'b0;
    end else if (deliver) begin
      adel_dec_d = deliver_adel;
      if (deliver_adel) begin
        halt_d = 1'b1;
      end
    end else if (!stallD) begin
      adel_dec_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel_dec_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      adel_dec_q <= adel_dec_d;
      halt_q     <= halt_d;
    end
  end
`else
  assign misaligned = 1'b0;
  assign idle_halt  = 1'b0;
  assign adelD      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    instr_dec_d  = instr_dec_q;
    pc_dec_d     = pc_dec_q;
    valid_dec_d  = valid_dec_q;
    hold_d       = hold_q;
    deliver      = 1'b0;
    deliver_adel = 1'b0;
    deliver_data = 32'h0;

    case (state_q)
      IDLE: begin
        if (!idle_halt) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (misaligned) begin
          if (!stallD) begin
            deliver      = 1'b1;
            deliver_adel = 1'b1;
            state_d      = IDLE;
          end
        end else if (inst_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (inst_data_ok) begin
          if (stallD) begin
            hold_d  = inst_rdata;
            state_d = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_data = inst_rdata;
            state_d      = ADDR;
          end
        end
      end
      HOLD: begin
        if (!stallD) begin
          deliver      = 1'b1;
          deliver_data = hold_q;
          state_d      = ADDR;
        end
      end
      DISCARD: begin
        if (inst_data_ok) begin
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase

    // An error delivery keeps pcF on the faulting address so the handler can report it.
    if (deliver) begin
      instr_dec_d = deliver_data;
      pc_dec_d    = pc_f_q;
      valid_dec_d = 1'b1;
      pc_f_d      = deliver_adel ? pc_f_q : pc_nextF;
    end else if (!stallD) begin
      instr_dec_d = 32'h0;
      valid_dec_d = 1'b0;
    end

    // A redirect overrides everything above; an accepted but unanswered request must be drained first.
    if (flush) begin
      pc_f_d      = flush_pc;
      instr_dec_d = 32'h0;
      valid_dec_d = 1'b0;
      hold_d      = hold_q;
      case (state_q)
        ADDR:    state_d = (inst_addr_ok && !misaligned) ? DISCARD : ADDR;
        DATA:    state_d = inst_data_ok ? ADDR : DISCARD;
        DISCARD: state_d = inst_data_ok ? ADDR : DISCARD;
        default: state_d = ADDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_f_q      <= RESET_PC;
      instr_dec_q <= 32'h0;
      pc_dec_q    <= 32'h0;
      valid_dec_q <= 1'b0;
      hold_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      instr_dec_q <= instr_dec_d;
      pc_dec_q    <= pc_dec_d;
      valid_dec_q <= valid_dec_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    stall_req_if = 1'b1;
    case (state_q)
      DATA:    stall_req_if = !inst_data_ok;
      HOLD:    stall_req_if = 1'b0;
      default: stall_req_if = 1'b1;
    endcase
  end

  assign inst_req  = (state_q == ADDR) && !misaligned;
  assign inst_wr   = 1'b0;
  assign inst_size = 2'b10;
  assign inst_addr = pc_f_q;
  assign pcF       = pc_f_q;
  assign instrD    = instr_dec_q;
  assign pcD       = pc_dec_q;
  assign validD    = valid_dec_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed scenarios plus a randomized run against an
// instruction-stream model (memory contents are a fixed hash of the address).
module tb_inst_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_nextF;
  logic        stallD;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        adelD;
  logic [31:0] pcF;
  logic        stall_req_if;

  int checks   = 0;
  int failures = 0;

  inst_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc_nextF(pc_nextF), .stallD(stallD), .flush(flush), .flush_pc(flush_pc),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .instrD(instrD), .pcD(pcD), .validD(validD), .adelD(adelD), .pcF(pcF), .stall_req_if(stall_req_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] m;
    m = a * 32'h9E3779B1;
    return m ^ {a[15:0], a[31:16]} ^ 32'h5A5A0000;
  endfunction

  // Inputs are always changed just after a falling edge; ends on a falling edge with the DUT in IDLE.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    stallD = 1'b0; flush = 1'b0; flush_pc = 32'h0; pc_nextF = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (inst_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    stallD = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1;
    checks++;
    if ({instrD, pcD, validD, adelD} !== 66'h0) begin
      failures++;
      $display("[TB] FAIL reset_decode: instrD=%h pcD=%h validD=%b adelD=%b, required all zero", instrD, pcD, validD, adelD);
    end
    checks++;
    if (pcF !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL reset_pcF: got %h, required %h", pcF, RESET_PC);
    end
    checks++;
    if ({inst_req, stall_req_if, inst_wr, inst_size} !== 5'b01010) begin
      failures++;
      $display("[TB] FAIL reset_bus: req=%b stall_req_if=%b wr=%b size=%b, required 0 1 0 10", inst_req, stall_req_if, inst_wr, inst_size);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL reset_first_req: req=%b addr=%h, required 1 %h", inst_req, inst_addr, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    wait_req();
    #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL basic_req: req=%b addr=%h, required 1 %h", inst_req, inst_addr, RESET_PC);
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h24080001; pc_nextF = 32'hBFC00004;
    #1;
    checks++;
    if (stall_req_if !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_stall_req: got %b, required 0 while data_ok", stall_req_if);
    end
    @(negedge clk);
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    checks++;
    if ({instrD, pcD, validD} !== {32'h24080001, 32'hBFC00000, 1'b1}) begin
      failures++;
      $display("[TB] FAIL basic_decode: instrD=%h pcD=%h validD=%b, required 24080001 bfc00000 1", instrD, pcD, validD);
    end
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'hBFC00004}) begin
      failures++;
      $display("[TB] FAIL basic_next_req: req=%b addr=%h, required 1 bfc00004", inst_req, inst_addr);
    end
  endtask

  task automatic test_stall_hold();
    stallD = 1'b1;
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h8C090010; pc_nextF = 32'hBFC00008;
    #1;
    checks++;
    if (stall_req_if !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_stall_req_data: got %b, required 0", stall_req_if);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inst_data_ok = 1'b0; inst_rdata = 32'h0;
      #1;
      checks++;
      if ({instrD, pcD, validD, stall_req_if, inst_req} !== {32'h24080001, 32'hBFC00000, 3'b100}) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d: instrD=%h pcD=%h validD=%b stall_req_if=%b req=%b, required 24080001 bfc00000 1 0 0",
                 i, instrD, pcD, validD, stall_req_if, inst_req);
      end
    end
    stallD = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({instrD, pcD, validD} !== {32'h8C090010, 32'hBFC00004, 1'b1}) begin
      failures++;
      $display("[TB] FAIL hold_release: instrD=%h pcD=%h validD=%b, required 8c090010 bfc00004 1", instrD, pcD, validD);
    end
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'hBFC00008}) begin
      failures++;
      $display("[TB] FAIL hold_next_req: req=%b addr=%h, required 1 bfc00008", inst_req, inst_addr);
    end
  endtask

  task automatic test_flush_discard();
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    flush = 1'b1; flush_pc = 32'hBFC00380;
    #1;
    checks++;
    if (stall_req_if !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_stall_req: got %b, required 1 while waiting for data", stall_req_if);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if ({validD, instrD, pcF, inst_req} !== {1'b0, 32'h0, 32'hBFC00380, 1'b0}) begin
      failures++;
      $display("[TB] FAIL flush_discard_state: validD=%b instrD=%h pcF=%h req=%b, required 0 0 bfc00380 0", validD, instrD, pcF, inst_req);
    end
    inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF;
    @(negedge clk);
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    checks++;
    if ({validD, instrD} !== 33'h0) begin
      failures++;
      $display("[TB] FAIL flush_stale_dropped: validD=%b instrD=%h, required 0 0", validD, instrD);
    end
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'hBFC00380}) begin
      failures++;
      $display("[TB] FAIL flush_redirect_req: req=%b addr=%h, required 1 bfc00380", inst_req, inst_addr);
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h11112222; pc_nextF = 32'hBFC00384;
    @(negedge clk);
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    checks++;
    if ({instrD, pcD, validD} !== {32'h11112222, 32'hBFC00380, 1'b1}) begin
      failures++;
      $display("[TB] FAIL flush_target_fetch: instrD=%h pcD=%h validD=%b, required 11112222 bfc00380 1", instrD, pcD, validD);
    end
  endtask

  task automatic test_addr_wait();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({inst_req, inst_addr, stall_req_if, validD} !== {1'b1, 32'hBFC00384, 1'b1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL addr_wait_cycle%0d: req=%b addr=%h stall_req_if=%b validD=%b, required 1 bfc00384 1 0",
                 i, inst_req, inst_addr, stall_req_if, validD);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wait_req();
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h24080001; pc_nextF = 32'hBFC00004;
    @(negedge clk);
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({instrD, pcD, validD, adelD, pcF} !== {66'h0, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL midreset_async: instrD=%h pcD=%h validD=%b adelD=%b pcF=%h, required 0 0 0 0 %h",
               instrD, pcD, validD, adelD, pcF, RESET_PC);
    end
    checks++;
    if ({inst_req, stall_req_if} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL midreset_bus: req=%b stall_req_if=%b, required 0 1", inst_req, stall_req_if);
    end
    @(negedge clk);
    rst = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    checks++;
    if ({validD, instrD, inst_req, inst_addr} !== {33'h0, 1'b1, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL midreset_stray_idle: validD=%b instrD=%h req=%b addr=%h, required 0 0 1 %h",
               validD, instrD, inst_req, inst_addr, RESET_PC);
    end
    @(negedge clk);
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    checks++;
    if ({validD, instrD, inst_req, inst_addr} !== {33'h0, 1'b1, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL midreset_stray_addr: validD=%b instrD=%h req=%b addr=%h, required 0 0 1 %h",
               validD, instrD, inst_req, inst_addr, RESET_PC);
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h3C1DBFC0; pc_nextF = 32'hBFC00004;
    @(negedge clk);
    inst_data_ok = 1'b0;
    #1;
    checks++;
    if ({instrD, pcD, validD} !== {32'h3C1DBFC0, RESET_PC, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midreset_restart: instrD=%h pcD=%h validD=%b, required 3c1dbfc0 %h 1", instrD, pcD, validD, RESET_PC);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    wait_req();
    flush = 1'b1; flush_pc = 32'hBFC00002;
    @(negedge clk);
    flush = 1'b0;
`ifdef FETCH_ADEL_EN
    #1;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL adel_no_req: req=%b, required 0", inst_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({validD, adelD, pcD, instrD} !== {2'b11, 32'hBFC00002, 32'h0}) begin
      failures++;
      $display("[TB] FAIL adel_deliver: validD=%b adelD=%b pcD=%h instrD=%h, required 1 1 bfc00002 0", validD, adelD, pcD, instrD);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({inst_req, validD, adelD} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL adel_parked%0d: req=%b validD=%b adelD=%b, required 0 0 0", i, inst_req, validD, adelD);
      end
    end
    flush = 1'b1; flush_pc = 32'hBFC00100;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if ({inst_req, inst_addr, adelD} !== {1'b1, 32'hBFC00100, 1'b0}) begin
      failures++;
      $display("[TB] FAIL adel_resume: req=%b addr=%h adelD=%b, required 1 bfc00100 0", inst_req, inst_addr, adelD);
    end
`else
    #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'hBFC00002}) begin
      failures++;
      $display("[TB] FAIL misaligned_req: req=%b addr=%h, required 1 bfc00002", inst_req, inst_addr);
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hA5A5A5A5; pc_nextF = 32'hBFC00006;
    @(negedge clk);
    inst_data_ok = 1'b0;
    #1;
    checks++;
    if ({instrD, pcD, validD, adelD} !== {32'hA5A5A5A5, 32'hBFC00002, 2'b10}) begin
      failures++;
      $display("[TB] FAIL misaligned_deliver: instrD=%h pcD=%h validD=%b adelD=%b, required a5a5a5a5 bfc00002 1 0",
               instrD, pcD, validD, adelD);
    end
`endif
  endtask

  // Model: the decode stage must present exactly the program stream (next PC = pc_nextF at delivery,
  // or flush_pc after a redirect) with words read from the model memory; the slave lives here too.
  task automatic test_random();
    logic [31:0] exp_pc, exp_instr, exp_pcd, pend_addr;
    logic [31:0] fpc_s, nxt_s, addr_s;
    logic        exp_valid, pend, stale, held;
    logic        st_s, fl_s, dok_s, req_s, aok_s, live;
    int          lat, delivered;
    apply_reset();
    exp_pc = RESET_PC; exp_instr = 32'h0; exp_pcd = 32'h0; exp_valid = 1'b0;
    pend = 1'b0; stale = 1'b0; held = 1'b0; lat = 0; delivered = 0; pend_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stallD       = ($urandom_range(0, 99) < 25);
      flush        = ($urandom_range(0, 99) < 4);
      flush_pc     = RESET_PC + ($urandom_range(0, 255) << 2);
      pc_nextF     = ($urandom_range(0, 3) == 0) ? RESET_PC + ($urandom_range(0, 255) << 2) : exp_pc + 32'd4;
      inst_data_ok = pend && (lat == 0);
      inst_rdata   = inst_data_ok ? mem_word(pend_addr) : $urandom();
      inst_addr_ok = inst_req && ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (pcF !== exp_pc) begin
        failures++;
        $display("[TB] FAIL rand_pcF cycle %0d: got %h, required %h", cyc, pcF, exp_pc);
      end
      checks++;
      if (inst_req && pend) begin
        failures++;
        $display("[TB] FAIL rand_single_outstanding cycle %0d: req=1 while a request is pending, required req=0", cyc);
      end
      if (inst_req) begin
        checks++;
        if (inst_addr !== exp_pc) begin
          failures++;
          $display("[TB] FAIL rand_inst_addr cycle %0d: got %h, required %h", cyc, inst_addr, exp_pc);
        end
      end
      checks++;
      if (stall_req_if !== !(held || (inst_data_ok && !stale))) begin
        failures++;
        $display("[TB] FAIL rand_stall_req_if cycle %0d: got %b, required %b", cyc, stall_req_if, !(held || (inst_data_ok && !stale)));
      end
      checks++;
      if ({inst_wr, inst_size, adelD} !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL rand_const cycle %0d: wr=%b size=%b adelD=%b, required 0 10 0", cyc, inst_wr, inst_size, adelD);
      end
      st_s = stallD; fl_s = flush; fpc_s = flush_pc; nxt_s = pc_nextF;
      dok_s = inst_data_ok; req_s = inst_req; aok_s = inst_addr_ok; addr_s = inst_addr;
      live = dok_s && !stale;
      @(negedge clk);
      if (dok_s) pend = 1'b0;
      else if (pend && lat > 0) lat--;
      if (req_s && aok_s) begin
        pend = 1'b1; pend_addr = addr_s; lat = $urandom_range(0, 3); stale = fl_s;
      end else if (pend && fl_s) begin
        stale = 1'b1;
      end
      if (fl_s) begin
        exp_instr = 32'h0; exp_valid = 1'b0; exp_pc = fpc_s; held = 1'b0;
      end else if (st_s) begin
        if (live) held = 1'b1;
      end else if (held || live) begin
        exp_instr = mem_word(exp_pc); exp_pcd = exp_pc; exp_valid = 1'b1; exp_pc = nxt_s; held = 1'b0;
        delivered++;
      end else begin
        exp_instr = 32'h0; exp_valid = 1'b0;
      end
      checks++;
      if ({instrD, validD} !== {exp_instr, exp_valid} || (exp_valid && pcD !== exp_pcd)) begin
        failures++;
        $display("[TB] FAIL rand_decode cycle %0d: instrD=%h pcD=%h validD=%b, required %h %h %b",
                 cyc, instrD, pcD, validD, exp_instr, exp_pcd, exp_valid);
      end
    end
    checks++;
    if (delivered < 50) begin
      failures++;
      $display("[TB] FAIL rand_progress: %0d instructions delivered, required at least 50", delivered);
    end
    stallD = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stallD = 1'b0; flush = 1'b0; flush_pc = 32'h0; pc_nextF = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    $display("[TB] inst_fetch_stage bench starting");
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_flush_discard();
    test_addr_wait();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
INST_FETCH_STAGE -- requirements
Module: inst_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port pc_nextF  input  32  next fetch address, sampled when an instruction is handed to decode.
REQ-005 SHALL have port stallD  input  1  decode stage holding; instrD/pcD/validD/adelD must not change.
REQ-006 SHALL have port flush  input  1  redirect request; discards in-flight and decode-stage instruction.
REQ-007 SHALL have port flush_pc  input  32  redirect target.
REQ-008 SHALL have ports inst_req out 1, inst_wr out 1 (constant 0), inst_size out 2 (constant 2'b10), inst_addr out 32: sram-like instruction request.
REQ-009 SHALL have ports inst_addr_ok in 1, inst_data_ok in 1, inst_rdata in 32: sram-like responses.
REQ-010 SHALL have ports instrD out 32, pcD out 32, validD out 1, adelD out 1: registered decode-stage instruction, its PC, valid flag, address-error flag.
REQ-011 SHALL have ports pcF out 32 (current fetch PC) and stall_req_if out 1 (fetch cannot deliver this cycle).

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA, HOLD, DISCARD; inst_req=1 only in ADDR; inst_addr=pcF.
REQ-013 IDLE SHALL go to ADDR unconditionally on the next edge.
REQ-014 ADDR: inst_addr SHALL stay stable until inst_addr_ok; on inst_addr_ok go to DATA.
REQ-015 DATA with inst_data_ok and !stallD SHALL load instrD=inst_rdata, pcD=pcF, validD=1, pcF=pc_nextF, state ADDR (one-cycle data_ok-to-instrD latency).
REQ-016 DATA with inst_data_ok and stallD SHALL capture inst_rdata into a hold register, state HOLD; decode outputs unchanged.
REQ-017 HOLD with !stallD SHALL transfer hold register to instrD (pcD=pcF, validD=1), pcF=pc_nextF, state ADDR.
REQ-018 When !stallD and no instruction is delivered this cycle, validD SHALL go to 0 and instrD to 0 (bubble).
REQ-019 stall_req_if SHALL be 1 in IDLE, ADDR, DISCARD, and in DATA without inst_data_ok; 0 otherwise.
REQ-020 flush SHALL have priority over stallD and all deliveries: pcF=flush_pc, validD=0, instrD=0, adelD=0.
REQ-021 flush in ADDR with inst_addr_ok=1, or in DATA without inst_data_ok, SHALL go to DISCARD.
REQ-022 flush in ADDR without inst_addr_ok, in HOLD, in DATA with inst_data_ok, or in IDLE SHALL go to ADDR (IDLE/ADDR keep request high with the new address).
REQ-023 DISCARD on inst_data_ok SHALL drop inst_rdata and go to ADDR; flush in DISCARD SHALL update pcF only.
REQ-024 At most one request SHALL be outstanding at any time.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, pcF=RESET_PC, instrD=0, pcD=0, validD=0, adelD=0, hold register 0.
REQ-026 rst asserted mid-transaction SHALL abandon it; a late inst_data_ok arriving while in IDLE or ADDR SHALL be ignored.

Configuration
REQ-027 Macro FETCH_ADEL_EN defined: in ADDR, if pcF[1:0]!=0 the block SHALL NOT assert inst_req; when !stallD it SHALL deliver instrD=0, pcD=pcF, validD=1, adelD=1, then enter IDLE and remain until flush.
REQ-028 Macro FETCH_ADEL_EN undefined: adelD SHALL be constant 0 and misaligned pcF SHALL be requested unchanged.

Verification
REQ-029 Reset release, addr_ok same cycle as req, data_ok next cycle with rdata=32'h24080001 -> instrD=32'h24080001, pcD=32'hBFC00000, validD=1; next inst_addr=pc_nextF.
REQ-030 data_ok while stallD=1 for 3 cycles -> instrD/pcD/validD unchanged for 3 cycles; instruction appears the edge after stallD falls.
REQ-031 flush with flush_pc=32'hBFC00380 while in DATA, then data_ok with rdata=32'hDEADBEEF -> DEADBEEF never reaches instrD; next inst_addr=32'hBFC00380.
REQ-032 addr_ok held low 5 cycles -> inst_req=1 and inst_addr constant all 5 cycles, stall_req_if=1, validD=0.
REQ-033 FETCH_ADEL_EN defined, flush_pc=32'hBFC00002 -> no inst_req, validD=1, adelD=1, pcD=32'hBFC00002; stays idle until next flush.
REQ-034 rst pulsed while in DATA, then stray data_ok -> all outputs at reset values, stray data ignored, fetch restarts at RESET_PC.
